data_mem_responder: RTL and testbench

Data-memory responder for the pipelined RV32I core: the target end of the core's MemRead/MemWrite/RWAddress/WriteData/MemData interface.
- Word RAM plus a small MMIO register bank: GPIO out, synchronized GPIO in, sticky error status, optional timer.
- Sits beside the core at top level; captures data on the rising clk edge so MemData is stable before the core's falling-edge M/W capture.

---
 rtl/data_mem_responder.sv | 170 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory target for the pipelined RV32I core: word RAM plus an MMIO bank (GPIO out/in, sticky error status).
// Optional MTIME/MTIMECMP timer with registered Irq is compiled in when DMEM_TIMER_EN is defined.
module data_mem_responder #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1001_0000,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 32'h1001_0800,
    parameter int                    GPIO_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [ADDR_WIDTH-1:0] RWAddress,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [GPIO_WIDTH-1:0] GPIO_In,
    output logic [DATA_WIDTH-1:0] MemData,
    output logic [GPIO_WIDTH-1:0] GPIO_Out,
    output logic                  AccessErr,
    output logic                  Irq
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] RAM_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] RAM_HI = RAM_LO + (ADDR_WIDTH + 1)'(4 * DEPTH);

`ifdef DMEM_TIMER_EN
    localparam int MMIO_SPAN = 'h14;
`else
    localparam int MMIO_SPAN = 'h0C;
`endif

    localparam logic [2:0] SEL_GPIO_OUT = 3'd0;
    localparam logic [2:0] SEL_GPIO_IN  = 3'd1;
    localparam logic [2:0] SEL_STATUS   = 3'd2;
    localparam logic [2:0] SEL_MTIME    = 3'd3;
    localparam logic [2:0] SEL_MTIMECMP = 3'd4;

    logic [ADDR_WIDTH:0]   addrExt;
    logic [ADDR_WIDTH-1:0] mmioOffset;
    logic [IDX_W-1:0]      ramIdx;
    logic [2:0]            regSel;
    logic                  ramHit;
    logic                  mmioHit;
    logic                  aligned;
    logic                  roWrite;
    logic                  badAccess;
    logic                  goodRead;
    logic                  goodWrite;
    logic                  ramWe;
    logic                  ramRe;
    logic                  mmioWe;
    logic                  statusClear;

    logic [DATA_WIDTH-1:0] ram [DEPTH];
    logic [DATA_WIDTH-1:0] ramRdReg;
    logic [DATA_WIDTH-1:0] mmioRdReg;
    logic [DATA_WIDTH-1:0] mmioRdValue;
    logic                  rdFromRamReg;
    logic [GPIO_WIDTH-1:0] gpioOutReg;
    logic [GPIO_WIDTH-1:0] gpioSync1Reg;
    logic [GPIO_WIDTH-1:0] gpioSync2Reg;
    logic                  accessErrReg;

    // Address decode: RAM window, MMIO window, alignment and read-only checks.
    assign addrExt    = {1'b0, RWAddress};
    assign mmioOffset = RWAddress - MMIO_BASE;
    assign ramIdx     = IDX_W'((RWAddress - BASE_ADDR) >> 2);
    assign regSel     = mmioOffset[4:2];
    assign ramHit     = (addrExt >= RAM_LO) && (addrExt < RAM_HI);
    assign mmioHit    = (RWAddress >= MMIO_BASE) && (mmioOffset < ADDR_WIDTH'(MMIO_SPAN));
    assign aligned    = (RWAddress[1:0] == 2'b00);
    assign roWrite    = MemWrite && mmioHit && (regSel == SEL_GPIO_IN);
    assign badAccess  = (MemRead || MemWrite) && (!(ramHit || mmioHit) || !aligned || roWrite);
    assign goodRead   = MemRead && !badAccess;
    assign goodWrite  = MemWrite && !badAccess;
    assign ramWe      = goodWrite && ramHit && !rst;
    assign ramRe      = goodRead && ramHit;
    assign mmioWe     = goodWrite && mmioHit;
    assign statusClear = mmioWe && (regSel == SEL_STATUS) && WriteData[0];

`ifdef DMEM_TIMER_EN
    logic [31:0] mtimeReg;
    logic [31:0] mtimeCmpReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            mtimeReg    <= 32'd0;
            mtimeCmpReg <= 32'hFFFF_FFFF;
            Irq         <= 1'b0;
        end else begin
            Irq <= (mtimeReg >= mtimeCmpReg);
            if (mmioWe && (regSel == SEL_MTIME)) begin
                mtimeReg <= WriteData[31:0];
            end else begin
                mtimeReg <= mtimeReg + 32'd1;
            end
            if (mmioWe && (regSel == SEL_MTIMECMP)) begin
                mtimeCmpReg <= WriteData[31:0];
            end
        end
    end
`else
    assign Irq = 1'b0;
`endif

    // MMIO read value is taken from pre-edge register contents.
    always_comb begin
        mmioRdValue = '0;
        case (regSel)
            SEL_GPIO_OUT: mmioRdValue[GPIO_WIDTH-1:0] = gpioOutReg;
            SEL_GPIO_IN:  mmioRdValue[GPIO_WIDTH-1:0] = gpioSync2Reg;
            SEL_STATUS:   mmioRdValue[0]              = accessErrReg;
`ifdef DMEM_TIMER_EN
            SEL_MTIME:    mmioRdValue[31:0]           = mtimeReg;
            SEL_MTIMECMP: mmioRdValue[31:0]           = mtimeCmpReg;
`endif
            default:      mmioRdValue = '0;
        endcase
    end

    // Block RAM with registered, enabled read so MemData holds between reads.
    always_ff @(posedge clk) begin
        if (ramWe) begin
            ram[ramIdx] <= WriteData;
        end
        if (ramRe) begin
            ramRdReg <= ram[ramIdx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gpioSync1Reg <= '0;
            gpioSync2Reg <= '0;
        end else begin
            gpioSync1Reg <= GPIO_In;
            gpioSync2Reg <= gpioSync1Reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdFromRamReg <= 1'b0;
            mmioRdReg    <= '0;
            gpioOutReg   <= '0;
            accessErrReg <= 1'b0;
        end else begin
            if (MemRead) begin
                rdFromRamReg <= ramRe;
                mmioRdReg    <= (goodRead && mmioHit) ? mmioRdValue : '0;
            end
            if (mmioWe && (regSel == SEL_GPIO_OUT)) begin
                gpioOutReg <= WriteData[GPIO_WIDTH-1:0];
            end
            // A bad access on the same edge as a clear keeps the flag set.
            if (badAccess) begin
                accessErrReg <= 1'b1;
            end else if (statusClear) begin
                accessErrReg <= 1'b0;
            end
        end
    end

    assign MemData   = rdFromRamReg ? ramRdReg : mmioRdReg;
    assign GPIO_Out  = gpioOutReg;
    assign AccessErr = accessErrReg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: spec-level model compared every cycle, plus literal spot checks.
module tb_data_mem_responder;

`ifdef DMEM_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    localparam logic [31:0] RAM_BASE = 32'h1001_0000;
    localparam logic [31:0] IO_BASE  = 32'h1001_0800;

    localparam int K_NONE = 0, K_RAM = 1, K_GOUT = 2, K_GIN = 3, K_STAT = 4, K_MTIME = 5, K_MCMP = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite;
    logic [31:0] RWAddress, WriteData;
    logic [7:0]  GPIO_In;
    logic [31:0] MemData;
    logic [7:0]  GPIO_Out;
    logic        AccessErr, Irq;

    int nVec = 0;
    int nFail = 0;

    data_mem_responder dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .RWAddress(RWAddress), .WriteData(WriteData), .GPIO_In(GPIO_In),
        .MemData(MemData), .GPIO_Out(GPIO_Out), .AccessErr(AccessErr), .Irq(Irq)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int kindOf(logic [31:0] a);
        int span;
        span = TIMER_EN ? 20 : 12;
        if (a >= RAM_BASE && a < RAM_BASE + 32'h400) return K_RAM;
        if (a >= IO_BASE && a < IO_BASE + 32'(span)) begin
            case ((a - IO_BASE) >> 2)
                0: return K_GOUT;
                1: return K_GIN;
                2: return K_STAT;
                3: return K_MTIME;
                default: return K_MCMP;
            endcase
        end
        return K_NONE;
    endfunction

    // Behavioural model: what the outputs must be after each rising edge.
    logic [31:0] memModel [int];
    logic [31:0] mData;
    bit          mDataKnown;
    logic [7:0]  mGpioOut;
    bit          mErr, mIrq, modelValid = 0;
    logic [31:0] mMtime, mCmp;
    logic [7:0]  gpioSeen1, gpioSeen2;

    always @(posedge clk) begin
        automatic logic        r = MemRead, w = MemWrite, rs = rst;
        automatic logic [31:0] a = RWAddress, d = WriteData;
        automatic logic [7:0]  g = GPIO_In;
        automatic int          k = kindOf(RWAddress);
        automatic bit          bad, clr = 0, nIrq;
        automatic logic [31:0] nMtime;
        automatic int          idx = int'((RWAddress - RAM_BASE) >> 2);
        if (rs) begin
            modelValid = 1; mData = 0; mDataKnown = 1; mGpioOut = 0;
            mErr = 0; mIrq = 0; mMtime = 0; mCmp = 32'hFFFF_FFFF;
            gpioSeen1 = 0; gpioSeen2 = 0;
        end else if (modelValid) begin
            bad = (r || w) && (k == K_NONE || a[1:0] != 2'b00 || (w && k == K_GIN));
            if (r) begin
                mDataKnown = 1;
                if (bad) mData = 0;
                else case (k)
                    K_RAM:   if (memModel.exists(idx)) mData = memModel[idx]; else mDataKnown = 0;
                    K_GOUT:  mData = {24'd0, mGpioOut};
                    K_GIN:   mData = {24'd0, gpioSeen2};
                    K_STAT:  mData = {31'd0, mErr};
                    K_MTIME: mData = mMtime;
                    default: mData = mCmp;
                endcase
            end
            nIrq = TIMER_EN && (mMtime >= mCmp);
            nMtime = mMtime + 1;
            if (w && !bad) begin
                case (k)
                    K_RAM:   memModel[idx] = d;
                    K_GOUT:  mGpioOut = d[7:0];
                    K_STAT:  clr = d[0];
                    K_MTIME: nMtime = d;
                    K_MCMP:  mCmp = d;
                    default: ;
                endcase
            end
            if (bad) mErr = 1; else if (clr) mErr = 0;
            mIrq = nIrq;
            mMtime = nMtime;
            gpioSeen2 = gpioSeen1;
            gpioSeen1 = g;
        end
        #1;
        if (modelValid) begin
            if (mDataKnown) chk("model MemData", MemData, mData);
            chk("model GPIO_Out", {24'd0, GPIO_Out}, {24'd0, mGpioOut});
            chk("model AccessErr", {31'd0, AccessErr}, {31'd0, mErr});
            chk("model Irq", {31'd0, Irq}, {31'd0, mIrq});
        end
    end

    task automatic cyc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        MemRead = r; MemWrite = w; RWAddress = a; WriteData = d;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; MemRead = 0; MemWrite = 0; RWAddress = 0; WriteData = 0; GPIO_In = 8'h5A;
        @(negedge clk);
        idle();
        chk("reset MemData", MemData, 32'h0);
        chk("reset AccessErr", {31'd0, AccessErr}, 32'h0);
        chk("reset GPIO_Out", {24'd0, GPIO_Out}, 32'h0);
        chk("reset Irq", {31'd0, Irq}, 32'h0);
        rst = 1'b0;

        cyc(0, 1, 32'h1001_0010, 32'hDEAD_BEEF);
        cyc(1, 0, 32'h1001_0010, 32'h0);
        chk("ram readback", MemData, 32'hDEAD_BEEF);
        chk("ram no err", {31'd0, AccessErr}, 32'h0);
        idle();
        chk("read hold", MemData, 32'hDEAD_BEEF);

        cyc(0, 1, 32'h1001_0000, 32'h0000_0055);
        cyc(0, 1, 32'h1001_03FC, 32'h1234_5678);
        cyc(1, 0, 32'h1001_03FC, 32'h0);
        chk("last word", MemData, 32'h1234_5678);
        cyc(0, 1, 32'h1001_0400, 32'h0BAD_F00D);
        chk("past end err", {31'd0, AccessErr}, 32'h1);
        cyc(1, 0, 32'h1001_03FC, 32'h0);
        chk("last word kept", MemData, 32'h1234_5678);
        cyc(1, 0, 32'h1001_0000, 32'h0);
        chk("word0 kept", MemData, 32'h0000_0055);
        cyc(1, 0, 32'h1001_0808, 32'h0);
        chk("status read", MemData, 32'h1);
        cyc(0, 1, 32'h1001_0808, 32'h1);
        chk("w1c clear", {31'd0, AccessErr}, 32'h0);

        cyc(1, 0, 32'h1001_0002, 32'h0);
        chk("misaligned data", MemData, 32'h0);
        chk("misaligned err", {31'd0, AccessErr}, 32'h1);
        cyc(0, 1, 32'h1001_0808, 32'h1);
        chk("w1c clear 2", {31'd0, AccessErr}, 32'h0);

        GPIO_In = 8'hA5;
        idle();
        cyc(1, 0, 32'h1001_0804, 32'h0);
        chk("gpio in +1", MemData, 32'h0000_005A);
        cyc(1, 0, 32'h1001_0804, 32'h0);
        chk("gpio in +2", MemData, 32'h0000_00A5);
        cyc(0, 1, 32'h1001_0800, 32'h0000_003C);
        chk("gpio out", {24'd0, GPIO_Out}, 32'h3C);
        cyc(1, 0, 32'h1001_0800, 32'h0);
        chk("gpio out read", MemData, 32'h0000_003C);
        cyc(0, 1, 32'h1001_0804, 32'h0000_00FF);
        chk("ro write err", {31'd0, AccessErr}, 32'h1);
        cyc(0, 1, 32'h1001_0808, 32'h1);

        cyc(0, 1, 32'h1001_0020, 32'h0000_0011);
        cyc(1, 1, 32'h1001_0020, 32'h0000_0022);
        chk("rw same old", MemData, 32'h0000_0011);
        cyc(1, 0, 32'h1001_0020, 32'h0);
        chk("rw same new", MemData, 32'h0000_0022);

        cyc(0, 1, 32'h1001_0810, 32'd10);
        cyc(0, 1, 32'h1001_080C, 32'd0);
        for (int i = 1; i <= 11; i++) begin
            idle();
            if (i == 10) chk("irq edge10", {31'd0, Irq}, 32'h0);
            if (i == 11) chk("irq edge11", {31'd0, Irq}, {31'd0, TIMER_EN});
        end
        cyc(1, 0, 32'h1001_080C, 32'h0);
        cyc(0, 1, 32'h1001_0810, 32'hFFFF_FFFF);
        chk("irq at cmp write", {31'd0, Irq}, {31'd0, TIMER_EN});
        idle();
        chk("irq cleared", {31'd0, Irq}, 32'h0);
        chk("timer err", {31'd0, AccessErr}, {31'd0, !TIMER_EN});

        rst = 1'b1;
        cyc(0, 1, 32'h1001_0010, 32'hCAFE_F00D);
        rst = 1'b0;
        chk("rst MemData", MemData, 32'h0);
        chk("rst GPIO_Out", {24'd0, GPIO_Out}, 32'h0);
        chk("rst AccessErr", {31'd0, AccessErr}, 32'h0);
        cyc(1, 0, 32'h1001_0010, 32'h0);
        chk("rst write dropped", MemData, 32'hDEAD_BEEF);
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
